w0rm_inst_fetch_unpacker: RTL

//  Single-line fetch buffer between the W0RM core instruction port and a 32-bit synchronous instruction ROM.

---
 rtl/w0rm_inst_fetch_unpacker.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/w0rm_inst_fetch_unpacker.sv
// w0rm_inst_fetch_unpacker: single-line fetch buffer between core and ROM.
// Returns the addressed INST_WIDTH half of a buffered 32-bit ROM word.
//
// Ports:
//   core_clk, reset_n           clock, async active-low reset
//   core_inst_addr_i/valid_i    halfword fetch request (bit1 selects half)
//   core_inst_ready_o           high while idle
//   core_inst_data_o/valid_o    response, valid is a one-cycle pulse
//   flush_i                     invalidate the buffered word
//   rom_en_o/rom_addr_o         ROM read strobe and word address
//   rom_data_i                  ROM read data, ROM_LATENCY cycles after rom_en_o
//   stat_hits_o/stat_misses_o   saturating counters (W0RM_FETCH_STATS_EN only)
//
// Build option: define W0RM_FETCH_STATS_EN to add the hit/miss counters.

module w0rm_inst_fetch_unpacker #(
    parameter int INST_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  core_clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] core_inst_addr_i,
    input  logic                  core_inst_valid_i,
    output logic                  core_inst_ready_o,
    output logic [INST_WIDTH-1:0] core_inst_data_o,
    output logic                  core_inst_valid_o,
    input  logic                  flush_i,
    output logic                  rom_en_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
`ifdef W0RM_FETCH_STATS_EN
    output logic [15:0]           stat_hits_o,
    output logic [15:0]           stat_misses_o,
`endif
    input  logic [DATA_WIDTH-1:0] rom_data_i
);

    localparam int TAG_W = ADDR_WIDTH - 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [3:0] LAT = 4'(ROM_LATENCY);

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [TAG_W-1:0]      lat_tag;
    logic                  lat_half;
    logic                  flush_seen;
    logic                  buf_valid;
    logic [TAG_W-1:0]      buf_tag;
    logic [DATA_WIDTH-1:0] buf_word;

    logic [TAG_W-1:0]      req_tag;
    logic                  hit;
    logic                  unused_addr_bit;

    assign req_tag = core_inst_addr_i[ADDR_WIDTH-1:2];
    assign unused_addr_bit = core_inst_addr_i[0];

    // Full-tag compare; a same-cycle flush forces a miss.
    assign hit = buf_valid && (req_tag == buf_tag) && !flush_i;

    assign core_inst_ready_o = (state == IDLE);
    assign rom_en_o          = (state == ISSUE);

    // Big-endian half order: addr[1]=0 takes the upper half.
    function automatic logic [INST_WIDTH-1:0] sel_half(
        input logic [DATA_WIDTH-1:0] word,
        input logic                  half
    );
        return half ? word[INST_WIDTH-1:0]
                    : word[DATA_WIDTH-1:INST_WIDTH];
    endfunction

    always_ff @(posedge core_clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            cnt               <= '0;
            lat_tag           <= '0;
            lat_half          <= 1'b0;
            flush_seen        <= 1'b0;
            buf_valid         <= 1'b0;
            buf_tag           <= '0;
            buf_word          <= '0;
            core_inst_valid_o <= 1'b0;
            core_inst_data_o  <= '0;
            rom_addr_o        <= '0;
        end else begin
            core_inst_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        buf_valid <= 1'b0;
                    end
                    if (core_inst_valid_i) begin
                        if (hit) begin
                            core_inst_valid_o <= 1'b1;
                            core_inst_data_o  <=
                                sel_half(buf_word, core_inst_addr_i[1]);
                        end else begin
                            lat_tag    <= req_tag;
                            lat_half   <= core_inst_addr_i[1];
                            rom_addr_o <= {req_tag, 2'b00};
                            flush_seen <= 1'b0;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt        <= LAT;
                    flush_seen <= flush_seen | flush_i;
                    state      <= WAIT;
                end
                WAIT: begin
                    cnt        <= cnt - 4'd1;
                    flush_seen <= flush_seen | flush_i;
                    if (cnt == 4'd1) begin
                        buf_word          <= rom_data_i;
                        buf_tag           <= lat_tag;
                        // A flush during the fill still answers the
                        // request but must not leave a usable line.
                        buf_valid         <= !(flush_seen | flush_i);
                        core_inst_valid_o <= 1'b1;
                        core_inst_data_o  <= sel_half(rom_data_i, lat_half);
                        state             <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef W0RM_FETCH_STATS_EN
    logic acc_hit;
    logic acc_miss;

    assign acc_hit  = (state == IDLE) && core_inst_valid_i && hit;
    assign acc_miss = (state == IDLE) && core_inst_valid_i && !hit;

    always_ff @(posedge core_clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_hits_o   <= '0;
            stat_misses_o <= '0;
        end else begin
            if (acc_hit && stat_hits_o != 16'hFFFF) begin
                stat_hits_o <= stat_hits_o + 16'd1;
            end
            if (acc_miss && stat_misses_o != 16'hFFFF) begin
                stat_misses_o <= stat_misses_o + 16'd1;
            end
        end
    end
`endif

endmodule
